// File: rtl/uart_intf_pkg.sv
// Shared definitions for the UART operand/result interface blocks:
// FSM encoding, default byte width and the byte-counter sizing rule.
package uart_intf_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

  // The counter must be able to hold NBYTES-1 without wrapping.
  function automatic bit cnt_w_fits(input int nbytes, input int cnt_w);
    return nbytes < (1 << cnt_w);
  endfunction

endpackage

// File: rtl/result_pending_slot.sv
// One-deep holding register for a result that arrives while the FSM is busy.
// Capture/release take effect next cycle; overrun pulses one cycle after a drop.
module result_pending_slot #(
  parameter int RES_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             store,
  input  logic             take,
  input  logic [RES_W-1:0] din,
  output logic [RES_W-1:0] dout,
  output logic             vld,
  output logic             overrun
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dout    <= '0;
      vld     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // A slot being released this cycle can accept the new result at once.
      overrun <= store && vld && !take;
      if (store && (!vld || take)) begin
        dout <= din;
        vld  <= 1'b1;
      end else if (take) begin
        vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_result_tx_intf.sv
// Serialises an ALU result into UART bytes, LSB first, one start/done handshake per byte.
// Start 1 cycle after accept, done 1 cycle after last tx_done; one result buffered, further ones dropped.
module alu_result_tx_intf
  import uart_intf_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int NBYTES = 1,
  parameter int CNT_W  = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic [NBYTES*DATA_W-1:0] i_result,
  input  logic                     i_tx_done,
  output logic                     o_tx_start,
  output logic [DATA_W-1:0]        o_tx_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_overrun
);

  localparam int RES_W = NBYTES * DATA_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  if (!cnt_w_fits(NBYTES, CNT_W)) begin : g_cnt_w_check
    $error("alu_result_tx_intf: CNT_W too narrow for NBYTES");
  end

  tx_state_t        state, state_n;
  logic [RES_W-1:0] shift, shift_n;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_n;
  logic [RES_W-1:0] pend_dat;
  logic             pend_vld;
  logic             store, take;

  assign take  = (state == IDLE) && pend_vld;
  assign store = i_valid && ((state != IDLE) || pend_vld);

  result_pending_slot #(.RES_W(RES_W)) u_pending (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .store   (store),
    .take    (take),
    .din     (i_result),
    .dout    (pend_dat),
    .vld     (pend_vld),
    .overrun (o_overrun)
  );

  always_comb begin
    state_n    = state;
    shift_n    = shift;
    byte_cnt_n = byte_cnt;
    case (state)
      IDLE: begin
        if (pend_vld) begin
          shift_n    = pend_dat;
          byte_cnt_n = '0;
          state_n    = START;
        end else if (i_valid) begin
          shift_n    = i_result;
          byte_cnt_n = '0;
          state_n    = START;
        end
      end
      START: state_n = WAIT;
      WAIT: begin
        if (i_tx_done) begin
          if (byte_cnt == LAST_CNT) begin
            state_n = DONE;
          end else begin
            shift_n    = shift >> DATA_W;
            byte_cnt_n = byte_cnt + CNT_W'(1);
            state_n    = START;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      shift      <= '0;
      byte_cnt   <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      byte_cnt   <= byte_cnt_n;
      o_tx_start <= (state_n == START);
      o_busy     <= (state_n != IDLE);
      o_done     <= (state_n == DONE);
      if (state_n == START) o_tx_data <= shift_n[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_alu_result_tx_intf.sv
// Bench for alu_result_tx_intf: one 1-byte and one 2-byte instance, driven by a
// cycle-stepped UART TX model and a word-level reference of accepted/dropped results.
module tb_alu_result_tx_intf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v1 = 1'b0, v2 = 1'b0, d1 = 1'b0, d2 = 1'b0;
  logic [7:0]  r1 = '0;
  logic [15:0] r2 = '0;
  logic        s1, s2, b1, b2, dn1, dn2, ov1, ov2;
  logic [7:0]  td1, td2;

  always #5 clk = ~clk;

  alu_result_tx_intf #(.DATA_W(8), .NBYTES(1), .CNT_W(3)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_valid(v1), .i_result(r1), .i_tx_done(d1),
    .o_tx_start(s1), .o_tx_data(td1), .o_busy(b1), .o_done(dn1), .o_overrun(ov1));

  alu_result_tx_intf #(.DATA_W(8), .NBYTES(2), .CNT_W(3)) u_dut2 (
    .i_clk(clk), .i_reset(rst), .i_valid(v2), .i_result(r2), .i_tx_done(d2),
    .o_tx_start(s2), .o_tx_data(td2), .o_busy(b2), .o_done(dn2), .o_overrun(ov2));

  bit sel = 1'b0;
  logic       o_s, o_b, o_dn, o_ov;
  logic [7:0] o_td;
  assign o_s  = sel ? s2  : s1;
  assign o_b  = sel ? b2  : b1;
  assign o_dn = sel ? dn2 : dn1;
  assign o_ov = sel ? ov2 : ov1;
  assign o_td = sel ? td2 : td1;

  int n_assert = 0, n_fail = 0;
  int occ = 0, tx_cnt = -1, bytes_done = 0, start_due = 0;
  int tx_dly = 4, n_done = 0, n_ovr = 0, n_start = 0;
  bit tx_rand = 1'b0, done_due = 1'b0, ovr_due = 1'b0, pop_now = 1'b0;
  logic [7:0] tx_cur = '0;
  logic [7:0] exp_bytes[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: decide inputs from the model, drive them, then sample at the falling edge.
  task automatic tick(input bit v, input logic [15:0] r, input bit spur, input bit rs);
    bit dn;
    bit exp_s;
    int nb;
    nb = sel ? 2 : 1;
    dn = 1'b0;
    done_due = 1'b0;
    ovr_due = 1'b0;
    if (!rs) begin
      if (v) begin
        if (occ < 2) begin
          if (occ == 0) start_due = 1;
          occ++;
          for (int k = 0; k < nb; k++) exp_bytes.push_back(r[k*8 +: 8]);
        end else begin
          ovr_due = 1'b1;
        end
      end
      if (tx_cnt == 0) begin
        dn = 1'b1;
        tx_cnt = -1;
        bytes_done++;
        if (bytes_done == nb) begin
          done_due = 1'b1;
          bytes_done = 0;
        end else begin
          start_due = 1;
        end
      end
      if (pop_now) begin
        occ--;
        if (occ > 0) start_due = 2;
      end
    end
    pop_now = 1'b0;
    rst = rs;
    v1 = v && !sel;
    v2 = v && sel;
    r1 = r[7:0];
    r2 = r;
    d1 = (dn || spur) && !sel;
    d2 = (dn || spur) && sel;
    @(negedge clk);
    if (rs) begin
      chk("rst_start1", s1, 0);  chk("rst_data1", td1, 0); chk("rst_busy1", b1, 0);
      chk("rst_done1", dn1, 0);  chk("rst_ovr1", ov1, 0);
      chk("rst_start2", s2, 0);  chk("rst_data2", td2, 0); chk("rst_busy2", b2, 0);
      chk("rst_done2", dn2, 0);  chk("rst_ovr2", ov2, 0);
      occ = 0; tx_cnt = -1; bytes_done = 0; start_due = 0;
      exp_bytes.delete();
      return;
    end
    exp_s = (start_due == 1);
    if (start_due > 0) start_due--;
    chk("tx_start", o_s, exp_s);
    chk("done", o_dn, done_due);
    chk("overrun", o_ov, ovr_due);
    if (o_ov === 1'b1) n_ovr++;
    if (o_dn === 1'b1) begin
      n_done++;
      pop_now = 1'b1;
      chk("busy_done", o_b, 1);
    end
    if (o_s === 1'b1) begin
      n_start++;
      chk("tx_byte", o_td, exp_bytes.size() > 0 ? {24'h0, exp_bytes.pop_front()} : 32'hDEAD_BEEF);
      tx_cur = o_td;
      tx_cnt = tx_rand ? int'($urandom_range(1, 5)) : tx_dly;
      chk("busy_start", o_b, 1);
    end else if (tx_cnt > 0) begin
      chk("tx_hold", o_td, tx_cur);
      chk("busy_wait", o_b, 1);
      tx_cnt--;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic run_until_done(input int max);
    int d0;
    int i;
    d0 = n_done;
    i = 0;
    while (n_done == d0 && i < max) begin
      tick(1'b0, 16'h0, 1'b0, 1'b0);
      i++;
    end
    chk("timeout_done", n_done != d0, 1);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_busy"}, o_b, 0);
    chk({tag, "_unsent"}, exp_bytes.size(), 0);
  endtask

  initial begin
    int d0, o0, st0, i;

    tick(1'b0, 16'h0, 1'b0, 1'b1);
    tick(1'b0, 16'h0, 1'b0, 1'b1);

    // Single byte, slow UART.
    sel = 1'b0; tx_dly = 10; d0 = n_done;
    tick(1'b1, 16'h00A5, 1'b0, 1'b0);
    run_until_done(40);
    run(2);
    expect_idle("t1");
    chk("t1_dones", n_done - d0, 1);

    // Two-byte word, LSB first.
    sel = 1'b1; tx_dly = 3; d0 = n_done;
    tick(1'b1, 16'h1234, 1'b0, 1'b0);
    run(20);
    expect_idle("t2");
    chk("t2_dones", n_done - d0, 1);

    // Pending capture then overrun.
    sel = 1'b0; tx_dly = 6; d0 = n_done; o0 = n_ovr;
    tick(1'b1, 16'h0011, 1'b0, 1'b0);
    run(2);
    tick(1'b1, 16'h0022, 1'b0, 1'b0);
    tick(1'b1, 16'h0033, 1'b0, 1'b0);
    run(40);
    expect_idle("t3");
    chk("t3_dones", n_done - d0, 2);
    chk("t3_ovr", n_ovr - o0, 1);

    // New result in the IDLE cycle that releases the pending slot.
    tx_dly = 4; d0 = n_done; o0 = n_ovr;
    tick(1'b1, 16'h0011, 1'b0, 1'b0);
    tick(1'b0, 16'h0000, 1'b0, 1'b0);
    tick(1'b1, 16'h0022, 1'b0, 1'b0);
    run_until_done(40);
    tick(1'b0, 16'h0000, 1'b0, 1'b0);
    tick(1'b1, 16'h0044, 1'b0, 1'b0);
    run(40);
    expect_idle("t4");
    chk("t4_dones", n_done - d0, 3);
    chk("t4_ovr", n_ovr - o0, 0);

    // Spurious tx_done in IDLE and START.
    st0 = n_start; d0 = n_done;
    tick(1'b0, 16'h0000, 1'b1, 1'b0);
    tick(1'b0, 16'h0000, 1'b1, 1'b0);
    tick(1'b1, 16'h0055, 1'b0, 1'b0);
    tick(1'b0, 16'h0000, 1'b1, 1'b0);
    run(20);
    expect_idle("t5");
    chk("t5_starts", n_start - st0, 1);
    chk("t5_dones", n_done - d0, 1);

    // Reset in WAIT of the second byte, with a result pending.
    sel = 1'b1; tx_dly = 4; st0 = n_start;
    tick(1'b1, 16'hBEEF, 1'b0, 1'b0);
    tick(1'b1, 16'h7777, 1'b0, 1'b0);
    i = 0;
    while (n_start - st0 < 2 && i < 40) begin
      tick(1'b0, 16'h0, 1'b0, 1'b0);
      i++;
    end
    chk("t6_second_start", n_start - st0, 2);
    tick(1'b0, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 16'h0000, 1'b0, 1'b1);
    st0 = n_start;
    run(10);
    chk("t6_no_resume", n_start - st0, 0);
    expect_idle("t6a");
    d0 = n_done;
    tick(1'b1, 16'h0102, 1'b0, 1'b0);
    run(20);
    expect_idle("t6b");
    chk("t6_dones", n_done - d0, 1);

    // Random traffic on both instances.
    tx_rand = 1'b1;
    for (int blk = 0; blk < 2; blk++) begin
      sel = (blk == 1);
      repeat (300) tick($urandom_range(0, 3) == 0, 16'($urandom), 1'b0, 1'b0);
      run(80);
      expect_idle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_tx_intf.md
Name: alu_result_tx_intf

Overview:
- TX-side counterpart of the UART RX operand collector.
- Accepts an ALU result word with a valid strobe and splits it into NBYTES bytes, LSB byte first.
- Hands each byte to the UART transmitter using a start/done handshake.
- Holds one extra result in a pending slot so a result arriving while busy is not lost; pulses o_done when the whole word has been sent.

Parameters:
- DATA_W, 8, UART byte width in bits.
- NBYTES, 1, number of bytes per result; result width is NBYTES*DATA_W.
- CNT_W, 3, width of the byte counter; must satisfy 2^CNT_W > NBYTES.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  one-cycle strobe: i_result is valid this cycle.
- i_result  in  NBYTES*DATA_W  ALU result to transmit.
- i_tx_done  in  1  UART TX pulse: the current byte has left the serializer.
- o_tx_start  out  1  one-cycle pulse: UART TX loads o_tx_data.
- o_tx_data  out  DATA_W  byte to transmit; stable from o_tx_start until i_tx_done.
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle pulse after the last byte of a word completes.
- o_overrun  out  1  one-cycle pulse when a result is dropped.

Behaviour:
- Reset (i_reset=1 on a clock edge), including mid-transfer:
  - state=IDLE, shift register=0, byte_cnt=0, pending_valid=0.
  - o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0, o_overrun=0.
  - A byte already started in UART TX is abandoned; the block does not wait for its i_tx_done.
- All outputs are registered.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - If pending_valid: load shift from pending, clear pending_valid, byte_cnt=0, go to START.
  - Else if i_valid: load shift from i_result, byte_cnt=0, go to START.
  - If pending_valid and i_valid are both high: pending is loaded into shift and i_result is captured into the freed pending slot. Nothing is dropped.
- START:
  - o_tx_start=1 for exactly one cycle; o_tx_data=shift[DATA_W-1:0].
  - Next state is WAIT.
- WAIT:
  - o_tx_start=0; o_tx_data is held.
  - On i_tx_done with byte_cnt==NBYTES-1: go to DONE.
  - On i_tx_done otherwise: shift right by DATA_W, byte_cnt+1, go to START.
- DONE:
  - o_done=1 for one cycle, then go to IDLE.
- i_tx_done sampled in IDLE, START or DONE is ignored; it is treated as spurious and has no effect.
- i_valid while not in IDLE:
  - If pending_valid=0: capture i_result into pending, set pending_valid.
  - If pending_valid=1: drop the new result, keep the old pending value, pulse o_overrun for one cycle.
- Latency:
  - i_valid at cycle t in IDLE gives o_tx_start at t+1.
  - Last i_tx_done at cycle u gives o_done at u+1.
  - A pending word's first o_tx_start appears at u+3 (DONE, IDLE, START).
- Byte order: byte k = i_result[k*DATA_W +: DATA_W], for k = 0..NBYTES-1.
- byte_cnt never exceeds NBYTES-1; no wrap-around occurs in a legal configuration.

Decomposition:
- Shared package (uart_intf_pkg):
  - State encoding constants IDLE=2'd0, START=2'd1, WAIT=2'd2, DONE=2'd3.
  - Default DATA_W=8.
  - The NBYTES/CNT_W consistency rule, shared with the RX collector.
- One natural sub-module: result_pending_slot.
  - One-deep holding register with capture/release/overrun logic.
  - Keeps the FSM file small.

Test Plan:
- NBYTES=1, i_valid with i_result=8'hA5; return i_tx_done 10 cycles after start -> o_tx_start at t+1 with o_tx_data=A5, data held through WAIT, o_done one cycle after i_tx_done, o_busy low afterwards.
- NBYTES=2, i_result=16'h1234 -> two o_tx_start pulses with data 34 then 12; exactly one o_done, after the second i_tx_done.
- While busy on 8'h11, send 8'h22 then 8'h33 -> 22 held in pending; o_overrun pulses on 33; bytes sent are 11 then 22, each followed by its own o_done; 33 is never sent.
- Pending 8'h22 set and i_valid 8'h44 in the IDLE cycle after DONE -> 22 sent, 44 captured into pending and sent next; no overrun.
- i_tx_done pulses in IDLE and START -> no state change, no extra bytes sent, no o_done.
- Assert i_reset during WAIT of the second byte of 16'hBEEF -> all outputs 0 the next cycle, pending cleared; a later i_valid 16'h0102 sends 02 then 01 cleanly.
